// File: rtl/hwce_types.sv
// Shared types and defaults for the HWCE sum-of-products controller.
package hwce_types;

    // Cycles from tap acceptance to the result on the SOP output (DSP_REGS+1+1)
    localparam int unsigned HWCE_PIPE_STAGES_SOP = 4;
    localparam int unsigned HWCE_FS_WIDTH        = 8;
    localparam int unsigned HWCE_NWIN_WIDTH      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sop_state_e;

endpackage

// File: rtl/hwce_tap_counter.sv
// Nested width/height/window tap counter with first/last flags.
module hwce_tap_counter
    import hwce_types::*;
#(
    parameter int unsigned FS_WIDTH   = HWCE_FS_WIDTH,
    parameter int unsigned NWIN_WIDTH = HWCE_NWIN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [FS_WIDTH-1:0]   fs_w_i,
    input  logic [FS_WIDTH-1:0]   fs_h_i,
    input  logic [NWIN_WIDTH-1:0] nb_win_i,
    input  logic                  adv_i,
    output logic                  first_o,
    output logic                  last_o,
    output logic                  job_last_o
);

    localparam logic [FS_WIDTH-1:0]   FS_ONE   = FS_WIDTH'(1);
    localparam logic [NWIN_WIDTH-1:0] NWIN_ONE = NWIN_WIDTH'(1);

    logic [FS_WIDTH-1:0]   fs_w_q, fs_h_q;
    logic [NWIN_WIDTH-1:0] nb_win_q;
    logic [FS_WIDTH-1:0]   cnt_w_q, cnt_w_d, cnt_h_q, cnt_h_d;
    logic [NWIN_WIDTH-1:0] cnt_win_q, cnt_win_d;
    logic                  w_end, h_end, win_end;

    // End-of-row/column/job detection against latched config minus one
    assign w_end      = (cnt_w_q == (fs_w_q - FS_ONE));
    assign h_end      = (cnt_h_q == (fs_h_q - FS_ONE));
    assign win_end    = (cnt_win_q == (nb_win_q - NWIN_ONE));
    assign first_o    = (cnt_w_q == '0) && (cnt_h_q == '0);
    assign last_o     = w_end && h_end;
    assign job_last_o = last_o && win_end;

    // Next counter values for an accepted tap
    always_comb begin
        cnt_w_d   = cnt_w_q + FS_ONE;
        cnt_h_d   = cnt_h_q;
        cnt_win_d = cnt_win_q;
        if (w_end) begin
            cnt_w_d = '0;
            cnt_h_d = h_end ? '0 : (cnt_h_q + FS_ONE);
        end
        if (last_o) begin
            cnt_win_d = win_end ? '0 : (cnt_win_q + NWIN_ONE);
        end
    end

    // Config latch on job load, counters advance only on accepted taps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fs_w_q    <= '0;
            fs_h_q    <= '0;
            nb_win_q  <= '0;
            cnt_w_q   <= '0;
            cnt_h_q   <= '0;
            cnt_win_q <= '0;
        end else if (clear_i) begin
            fs_w_q    <= '0;
            fs_h_q    <= '0;
            nb_win_q  <= '0;
            cnt_w_q   <= '0;
            cnt_h_q   <= '0;
            cnt_win_q <= '0;
        end else if (load_i) begin
            fs_w_q    <= fs_w_i;
            fs_h_q    <= fs_h_i;
            nb_win_q  <= nb_win_i;
            cnt_w_q   <= '0;
            cnt_h_q   <= '0;
            cnt_win_q <= '0;
        end else if (adv_i) begin
            cnt_w_q   <= cnt_w_d;
            cnt_h_q   <= cnt_h_d;
            cnt_win_q <= cnt_win_d;
        end
    end

endmodule

// File: rtl/hwce_sop_ctrl.sv
// HWCE sum-of-products sequencer: tap handshake, SOP controls, result tracking.
module hwce_sop_ctrl
    import hwce_types::*;
#(
    parameter int unsigned PIPE_STAGES_SOP = HWCE_PIPE_STAGES_SOP,
    parameter int unsigned FS_WIDTH        = HWCE_FS_WIDTH,
    parameter int unsigned NWIN_WIDTH      = HWCE_NWIN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  start,
    input  logic [FS_WIDTH-1:0]   fs_w,
    input  logic [FS_WIDTH-1:0]   fs_h,
    input  logic [NWIN_WIDTH-1:0] nb_win,
    input  logic                  x_valid_i,
    output logic                  x_ready_o,
    input  logic                  y_ready_i,
    output logic                  sop_valid_x_o,
    output logic                  sop_zero_o,
    output logic                  sop_enable_o,
    output logic                  y_valid_o,
    output logic                  busy_o,
    output logic                  done_o
);

    sop_state_e                 state_q;
    logic [PIPE_STAGES_SOP-1:0] pipe_q, pipe_d;
    logic                       load, cfg_zero, accept;
    logic                       tap_first, tap_last, tap_job_last;

    assign load     = (state_q == ST_IDLE) && start;
    assign cfg_zero = (fs_w == '0) || (fs_h == '0) || (nb_win == '0);

    // Handshake and SOP control decode
    assign x_ready_o     = (state_q == ST_ACCUM) && y_ready_i;
    assign accept        = x_valid_i && x_ready_o;
    assign sop_valid_x_o = accept;
    assign sop_zero_o    = accept && tap_first;
    assign busy_o        = (state_q != ST_IDLE);
    assign sop_enable_o  = busy_o && y_ready_i;
    assign done_o        = (state_q == ST_DONE);
    assign y_valid_o     = pipe_q[PIPE_STAGES_SOP-1];

    hwce_tap_counter #(
        .FS_WIDTH   (FS_WIDTH),
        .NWIN_WIDTH (NWIN_WIDTH)
    ) u_tap_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear),
        .load_i     (load),
        .fs_w_i     (fs_w),
        .fs_h_i     (fs_h),
        .nb_win_i   (nb_win),
        .adv_i      (accept),
        .first_o    (tap_first),
        .last_o     (tap_last),
        .job_last_o (tap_job_last)
    );

    // Last-tap marker shifts with the MACC pipeline, frozen while downstream stalls
    always_comb begin
        pipe_d = pipe_q;
        if (y_ready_i) begin
            pipe_d = PIPE_STAGES_SOP'({pipe_q, accept && tap_last});
        end
    end

    // Marker pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else if (clear) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // Job FSM; DRAIN exits once the pipeline will be empty after this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else if (clear) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= cfg_zero ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept && tap_job_last) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_d == '0) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/hwce_sop_ctrl.md
Name: hwce_sop_ctrl

Overview:
Sequencer for the HWCE sum-of-products datapath (NPX DSP MACC lanes sharing one weight). It accepts the pixel/weight tap stream and counts taps over a fs_w x fs_h filter window. It drives the SOP valid, accumulator-zero and enable controls. It tracks the MACC pipeline and flags when each window's accumulated result is valid at the SOP output, plus busy/done status for the engine FSM.

Parameters:
PIPE_STAGES_SOP, 4, cycles from tap acceptance to the result on the SOP output (DSP_REGS+1+1)
FS_WIDTH, 8, width of filter-size configuration fields
NWIN_WIDTH, 16, width of the window-count field

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
clear  in  1  synchronous soft reset of the whole job
start  in  1  job start pulse, sampled in IDLE only
fs_w  in  FS_WIDTH  filter width in taps
fs_h  in  FS_WIDTH  filter height in taps
nb_win  in  NWIN_WIDTH  number of windows in the job
x_valid_i  in  1  upstream tap (x_in/w_in) valid
x_ready_o  out  1  upstream tap ready
y_ready_i  in  1  downstream consumer ready; low freezes the datapath
sop_valid_x_o  out  1  to SOP valid_x_in
sop_zero_o  out  1  to SOP valid_y_out (MACC accumulator zero/restart)
sop_enable_o  out  1  to SOP enable
y_valid_o  out  1  SOP y_out holds a finished window result
busy_o  out  1  job in progress
done_o  out  1  one-cycle end-of-job pulse

Behaviour:
- Reset (rst_n low, async) and clear (sync, highest priority) both force: state IDLE, all counters 0, pipeline markers 0, every output 0.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE: on start, latch fs_w, fs_h, nb_win. If any of them is 0, go to DONE and issue no taps. Otherwise go to ACCUM. busy_o=0.
- ACCUM: x_ready_o = y_ready_i. A tap is accepted when x_valid_i && x_ready_o.
  - sop_valid_x_o = accepted (combinational).
  - sop_zero_o = accepted && cnt_w==0 && cnt_h==0, i.e. the first tap of a window restarts the accumulator.
- Tap counters advance only on acceptance:
  - cnt_w increments; at fs_w-1 it wraps to 0 and cnt_h increments.
  - At cnt_w==fs_w-1 && cnt_h==fs_h-1, both wrap to 0 and cnt_win increments. This accepted tap is marked "last".
  - The last tap of window nb_win-1 moves the FSM to DRAIN.
- Marker pipeline: a PIPE_STAGES_SOP-deep shift register carries the "last" flag. It shifts only when y_ready_i=1; when y_ready_i=0 it holds.
- y_valid_o = output stage of the marker pipeline. It stays high while y_ready_i=0. A result transfers on y_valid_o && y_ready_i.
- Latency: the result is valid PIPE_STAGES_SOP y_ready_i-high cycles after the window's last tap is accepted. With no stalls that is exactly 4 cycles.
- sop_enable_o = busy_o && y_ready_i.
- DRAIN: x_ready_o=0. Stay until the marker pipeline is all zero and no transfer is pending, then go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o=1 in ACCUM, DRAIN and DONE.
- start outside IDLE is ignored.
- fs_w=fs_h=1: every accepted tap is both first and last (sop_zero_o and the marker set together).
- Back-to-back windows: the first tap of window k+1 may be accepted the cycle after the last tap of window k, with no bubble.
- clear mid-job: in-flight markers are dropped, y_valid_o falls next cycle, no done_o.
- Counter widths: cnt_w/cnt_h FS_WIDTH bits, cnt_win NWIN_WIDTH bits. Comparisons use the latched values minus 1, evaluated only for nonzero configurations.

Decomposition:
- Shared package hwce_types: the state enum (IDLE/ACCUM/DRAIN/DONE) and the PIPE_STAGES_SOP default, so the SOP and the controller stay consistent.
- One natural sub-module: hwce_tap_counter (nested w/h/window counter with first/last flags and wrap). The FSM and marker pipeline stay in the top.

Test Plan:
- fs_w=3, fs_h=3, nb_win=1, x_valid_i always 1, y_ready_i=1 -> 9 sop_valid_x_o cycles; sop_zero_o on tap 0 only; y_valid_o one cycle, 4 cycles after tap 8; done_o 1 cycle later; busy_o low afterwards.
- fs_w=2, fs_h=2, nb_win=3, continuous input -> sop_zero_o on taps 0, 4, 8; y_valid_o pulses 4 cycles after taps 3, 7, 11; 12 taps total with no bubbles.
- Same as test 1 with y_ready_i low for 5 cycles after tap 4 -> x_ready_o=0, sop_enable_o=0 and counters frozen during the stall; y_valid_o is delayed by exactly 5 cycles; result count unchanged.
- y_ready_i low while y_valid_o=1 -> y_valid_o held high until y_ready_i rises; one transfer only.
- fs_w=1, fs_h=1, nb_win=4, x_valid_i toggling 1/0 -> each accepted tap carries sop_zero_o; 4 y_valid_o pulses each 4 cycles after its tap; done_o once.
- start with fs_h=0 -> no taps, done_o 1 cycle after start. Separately, clear asserted at tap 5 of a 3x3 job -> all outputs 0 next cycle, no y_valid_o, no done_o; a fresh start works normally.
